// File: rtl/lsu_router_pkg.sv
// rtl/lsu_router_pkg.sv - shared state encoding, error data and default slave address map.
package lsu_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

  // Index 0 is the leftmost entry, so the literal reads slave 0 first.
  localparam logic [0:3][31:0] DEF_SLV_BASE = {32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_4000};
  localparam logic [0:3][31:0] DEF_SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_C000};

endpackage

// File: rtl/lsu_addr_decode.sv
// rtl/lsu_addr_decode.sv - combinational base/mask decoder; lowest matching slave wins.
module lsu_addr_decode
  import lsu_router_pkg::*;
#(
  parameter int                         N_SLV    = 4,
  parameter logic [0:N_SLV-1][31:0]     SLV_BASE = DEF_SLV_BASE,
  parameter logic [0:N_SLV-1][31:0]     SLV_MASK = DEF_SLV_MASK
) (
  input  logic [31:0]      addr,
  output logic [N_SLV-1:0] hit,
  output logic             miss
);

  logic found;

  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!found && ((addr & SLV_MASK[i]) == SLV_BASE[i])) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/lsu_rdata_router.sv
// rtl/lsu_rdata_router.sv - routes one LSU access at a time to a decoded slave and returns its response.
// Optional WAIT timeout is built only when ROUTER_TIMEOUT_EN is defined.
module lsu_rdata_router
  import lsu_router_pkg::*;
#(
  parameter int                     N_SLV    = 4,
  parameter logic [0:N_SLV-1][31:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [0:N_SLV-1][31:0] SLV_MASK = DEF_SLV_MASK,
  parameter int                     TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_we,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_be,
  output logic [N_SLV-1:0]      slv_sel,
  output logic [31:0]           slv_addr,
  output logic                  slv_we,
  output logic [31:0]           slv_wdata,
  output logic [3:0]            slv_be,
  input  logic [N_SLV-1:0]      slv_rvalid,
  input  logic [N_SLV*32-1:0]   slv_rdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  state_t            state_q, state_d;
  logic [N_SLV-1:0]  hit;
  logic              miss;
  logic [N_SLV-1:0]  sel_q;
  logic              accept;
  logic              sel_rvalid;
  logic [31:0]       sel_rdata;
  logic              rsp_ld;
  logic              rsp_err_d;
  logic [31:0]       rsp_rdata_d;

  lsu_addr_decode #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr (req_addr),
    .hit  (hit),
    .miss (miss)
  );

  assign accept     = (state_q == ST_IDLE) && req_valid;
  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  // sel_q persists through WAIT for the rdata mux; the bus select is ACCESS-only.
  assign slv_sel    = (state_q == ST_ACCESS) ? sel_q : '0;
  assign sel_rvalid = |(slv_rvalid & sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | slv_rdata[32*i +: 32];
    end
  end

`ifdef ROUTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= '0;
    else if (state_q == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                        wait_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    rsp_ld      = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (miss) begin
            state_d     = ST_RESP;
            rsp_ld      = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = ERR_RDATA;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (slv_we) begin
          state_d = ST_RESP;
          rsp_ld  = 1'b1;
        end else if (sel_rvalid) begin
          state_d     = ST_RESP;
          rsp_ld      = 1'b1;
          rsp_rdata_d = sel_rdata;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sel_rvalid) begin
          state_d     = ST_RESP;
          rsp_ld      = 1'b1;
          rsp_rdata_d = sel_rdata;
        end
`ifdef ROUTER_TIMEOUT_EN
        else if (timed_out) begin
          state_d     = ST_RESP;
          rsp_ld      = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_RDATA;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      slv_addr  <= '0;
      slv_we    <= 1'b0;
      slv_wdata <= '0;
      slv_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        sel_q     <= hit;
        slv_addr  <= req_addr;
        slv_we    <= req_we;
        slv_wdata <= req_wdata;
        slv_be    <= req_be;
      end
      if (rsp_ld) begin
        rsp_rdata <= rsp_rdata_d;
        rsp_err   <= rsp_err_d;
      end
    end
  end

endmodule

// File: tb/tb_lsu_rdata_router.sv
// tb/tb_lsu_rdata_router.sv - randomized transaction bench with a transaction-level reference model.
module tb_lsu_rdata_router;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_we;
  logic [31:0]  req_wdata;
  logic [3:0]   req_be;
  logic [3:0]   slv_sel;
  logic [31:0]  slv_addr;
  logic         slv_we;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_be;
  logic [3:0]   slv_rvalid;
  logic [127:0] slv_rdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] base_tab [4] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_4000};
  logic [31:0] mask_tab [4] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_C000};

  always #5 clk = ~clk;

  lsu_rdata_router #(.N_SLV(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
    .slv_sel(slv_sel), .slv_addr(slv_addr), .slv_we(slv_we),
    .slv_wdata(slv_wdata), .slv_be(slv_be),
    .slv_rvalid(slv_rvalid), .slv_rdata(slv_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & mask_tab[i]) == base_tab[i]) return i;
    return -1;
  endfunction

  task automatic randomize_slaves();
    slv_rvalid = 4'($urandom);
    for (int i = 0; i < 4; i++) slv_rdata[32*i +: 32] = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'(1));
    check({tag, "_sel"},   64'(slv_sel),   64'(0));
    check({tag, "_addr"},  64'(slv_addr),  64'(0));
    check({tag, "_we"},    64'(slv_we),    64'(0));
    check({tag, "_wdata"}, 64'(slv_wdata), 64'(0));
    check({tag, "_be"},    64'(slv_be),    64'(0));
    check({tag, "_rvld"},  64'(rsp_valid), 64'(0));
    check({tag, "_rdata"}, 64'(rsp_rdata), 64'(0));
    check({tag, "_err"},   64'(rsp_err),   64'(0));
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle following RESP.
  // d = cycle after acceptance in which the selected slave pulses rvalid (loads only).
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be, input int d, input bit hold);
    int          s, lat, guard;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_sel;
    s = decode(addr);
    guard = 0;
    while (!req_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("ready_at_issue", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wdata; req_be = be;
    slv_rvalid = '0;
    exp_sel  = (s < 0) ? 4'b0000 : 4'(1 << s);
    exp_data = 32'h0;
    exp_err  = 1'b0;
    if (s < 0) begin
      lat = 1; exp_err = 1'b1; exp_data = 32'hDEADBEEF;
    end else if (we) begin
      lat = 2;
    end else begin
      lat = (d < 2) ? 2 : d + 1;
`ifdef ROUTER_TIMEOUT_EN
      if (d > TMO + 1) begin
        lat = TMO + 2; exp_err = 1'b1; exp_data = 32'hDEADBEEF;
      end
`endif
    end
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      randomize_slaves();
      if (s >= 0 && !we) begin
        slv_rvalid[s] = (k == d);
        if (k == d && !exp_err) exp_data = slv_rdata[32*s +: 32];
      end
      check("slv_sel", 64'(slv_sel), 64'((k == 1) ? exp_sel : 4'b0000));
      if (k == 1 && s >= 0) begin
        check("slv_addr",  64'(slv_addr),  64'(addr));
        check("slv_we",    64'(slv_we),    64'(we));
        check("slv_wdata", 64'(slv_wdata), 64'(wdata));
        check("slv_be",    64'(slv_be),    64'(be));
      end
      check("rsp_valid", 64'(rsp_valid), 64'(k == lat));
      check("req_ready", 64'(req_ready), 64'(k == lat + 1));
      if (k >= lat) begin
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_data));
        check("rsp_err",   64'(rsp_err),   64'(exp_err));
      end
    end
    slv_rvalid = '0;
  endtask

  task automatic reset_mid_wait();
    req_valid = 1'b1; req_addr = 32'h0000_4010; req_we = 1'b0; req_wdata = 32'h0; req_be = 4'hF;
    slv_rvalid = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      randomize_slaves();
      check("rst_hold_rvld", 64'(rsp_valid), 64'(0));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("post_rst_rvld", 64'(rsp_valid), 64'(0));
    end
    slv_rvalid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, wd;
    logic        we;
    int          mode, d;
    bit          hold;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; req_be = '0;
    slv_rvalid = '0; slv_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(32'h0000_1004, 1'b0, 32'h0, 4'hF, 2, 1'b0);
    do_txn(32'h0001_0000, 1'b0, 32'h0, 4'hF, 2, 1'b0);
    do_txn(32'h0000_2008, 1'b1, 32'hCAFEF00D, 4'b1111, 0, 1'b0);
    do_txn(32'h0000_0040, 1'b0, 32'h0, 4'h3, 1, 1'b0);
    do_txn(32'h0000_4000, 1'b0, 32'h0, 4'hF, 25, 1'b0);
    do_txn(32'h0000_3FFC, 1'b0, 32'h0, 4'hF, 17, 1'b0);
    reset_mid_wait();
    do_txn(32'h0000_1008, 1'b0, 32'h0, 4'hF, 3, 1'b0);
    do_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 2, 1'b1);
    do_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 2, 1'b0);

    for (int t = 0; t < 80; t++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0, 1: a = $urandom & 32'h0000_7FFF;
        2:    a = $urandom;
        default: a = 32'h0000_8000 | ($urandom & 32'h000F_FFFF);
      endcase
      we   = 1'($urandom);
      wd   = $urandom;
      d    = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 22) : $urandom_range(1, 5);
      hold = ($urandom_range(0, 3) == 0);
      do_txn(a, we, wd, 4'($urandom), d, hold);
      if (hold) do_txn(a, we, wd, req_be, d, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_rdata_router.md
LSU_RDATA_ROUTER -- requirements
Module: lsu_rdata_router

Interface
REQ-001 Parameter N_SLV, default 4: number of slave channels, range 2..8.
REQ-002 Parameter SLV_BASE, default {32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_4000}: per-slave base address.
REQ-003 Parameter SLV_MASK, default {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_C000}: per-slave address mask.
REQ-004 Parameter TIMEOUT, default 16: maximum cycles to wait for slave read data.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  1  LSU request present.
REQ-008 req_ready  output  1  router can accept a request.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_we  input  1  1 = store, 0 = load.
REQ-011 req_wdata  input  32  store data.
REQ-012 req_be  input  4  byte enables.
REQ-013 slv_sel  output  N_SLV  one-hot slave select.
REQ-014 slv_addr, slv_we, slv_wdata, slv_be  output  32/1/32/4  registered copy of the accepted request.
REQ-015 slv_rvalid  input  N_SLV  per-slave read-data valid.
REQ-016 slv_rdata  input  N_SLV*32  per-slave read data; slave i occupies bits [32i+31:32i].
REQ-017 rsp_valid  output  1  one-cycle response strobe to the LSU.
REQ-018 rsp_rdata  output  32  load data.
REQ-019 rsp_err  output  1  unmapped access or timeout.

Function
REQ-020 Decode: slave i hits when (req_addr & SLV_MASK[i]) == SLV_BASE[i]; the lowest index wins on overlap.
REQ-021 States: IDLE, ACCESS, WAIT, RESP.
REQ-022 IDLE: req_ready=1; on req_valid, latch the request, drive slv_sel with the hit, go to ACCESS; with no hit, go to RESP with rsp_err=1 and rsp_rdata=32'hDEADBEEF.
REQ-023 ACCESS: slv_sel is held for exactly one cycle; a store goes to RESP with rsp_rdata=0; a load goes to WAIT.
REQ-024 WAIT: on slv_rvalid[sel], capture slv_rdata[sel] and go to RESP; slv_rvalid of non-selected slaves is ignored.
REQ-025 RESP: rsp_valid=1 for exactly one cycle, then go to IDLE; req_ready=0 in all states except IDLE.
REQ-026 Latency: a load whose rvalid arrives in the first WAIT cycle gives rsp_valid 3 cycles after acceptance; a store gives 2; an unmapped access gives 1.
REQ-027 rsp_rdata and rsp_err hold their values until the next RESP.
REQ-028 If slv_rvalid[sel] is asserted during ACCESS, it is captured and WAIT is skipped.
REQ-029 A req_valid asserted while busy is not accepted; the LSU holds it until req_ready is high.

Reset
REQ-030 Reset value of every output while rst_n=0: state IDLE, req_ready=1, slv_sel=0, slv_addr/slv_wdata=0, slv_we=0, slv_be=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
REQ-031 A reset asserted mid-transaction aborts it, and no rsp_valid follows.

Configuration
REQ-032 With ROUTER_TIMEOUT_EN defined: a WAIT-cycle counter runs; when it reaches TIMEOUT-1 without rvalid, the router goes to RESP with rsp_err=1 and rsp_rdata=32'hDEADBEEF.
REQ-033 Without ROUTER_TIMEOUT_EN: no counter is built, and WAIT lasts indefinitely.

Structure
REQ-034 Package lsu_router_pkg holds the state enum, the 32'hDEADBEEF error constant and the default base/mask constants.
REQ-035 Sub-module lsu_addr_decode is combinational: it takes the address and returns a one-hot hit vector and a miss flag.

Verification
REQ-036 Load to 0x0000_1004, slave 1 returns 0x1234_5678 in the first WAIT cycle -> slv_sel=4'b0010 for one cycle; rsp_valid 3 cycles after acceptance, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-037 Load to 0x0001_0000 (unmapped) -> no slv_sel; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0xDEADBEEF.
REQ-038 Store 0xCAFEF00D to 0x0000_2008 with be=4'b1111 -> slv_sel=4'b0100, slv_wdata=0xCAFEF00D, slv_we=1; rsp_valid 2 cycles after acceptance with rsp_err=0.
REQ-039 Load to slave 3 with no rvalid, ROUTER_TIMEOUT_EN defined, TIMEOUT=16 -> rsp_valid after 16 WAIT cycles, rsp_err=1, rsp_rdata=0xDEADBEEF.
REQ-040 rst_n driven low during WAIT -> all outputs return to reset values immediately; no rsp_valid follows; the next request completes normally.
REQ-041 Back-to-back req_valid held high during RESP -> the second request is accepted only in the following IDLE cycle.
